// File: rtl/bch_pkg.sv
// Shared GF(16) / BCH(15,7) definitions used by the key-equation solver and its multiplier.
package bch_pkg;

    typedef logic [3:0] gf16_t;

    // Low-order terms of x^4 + x + 1, folded back in when a product overflows bit 3.
    localparam gf16_t GF_PRIM_POLY = 4'b0011;
    localparam int    BCH_N        = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } kes_state_t;

endpackage

// File: rtl/gf_multiplier.sv
// Combinational GF(16) multiplier, polynomial basis, reduced by x^4 + x + 1.
module gf_multiplier
    import bch_pkg::*;
(
    input  gf16_t a,
    input  gf16_t b,
    output gf16_t p
);

    gf16_t acc;
    gf16_t shifted;

    // Shift-and-add: shifted holds a*x^i, reduced modulo the primitive polynomial.
    always_comb begin
        acc     = '0;
        shifted = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ shifted;
            end
            if (shifted[3]) begin
                shifted = {shifted[2:0], 1'b0} ^ GF_PRIM_POLY;
            end else begin
                shifted = {shifted[2:0], 1'b0};
            end
        end
        p = acc;
    end

endmodule

// File: rtl/bch_key_eq_solver.sv
// Peterson key-equation solver for BCH(15,7) t=2 using one shared GF(16) multiplier.
// Optional macro BCH_KES_FAIL_DETECT_EN flags S1=0 with S3!=0 as uncorrectable.
module bch_key_eq_solver
    import bch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] s1,
    input  logic [3:0] s3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] lambda1,
    output logic [3:0] lambda2,
    output logic [1:0] err_cnt,
    output logic       uncorrectable
);

    kes_state_t state;
    logic [2:0] step;
    gf16_t      syn1;
    gf16_t      syn3;
    gf16_t      chain;
    gf16_t      cube;
    gf16_t      mul_a;
    gf16_t      mul_b;
    gf16_t      mul_p;

    // Operand schedule: S1^2, S1^3, S1^6, S1^7, S1^14 (= S1^-1), then (S3 + S1^3) * S1^-1.
    always_comb begin
        mul_a = chain;
        mul_b = syn1;
        case (step)
            3'd0: begin mul_a = syn1;        mul_b = syn1;  end
            3'd1: begin mul_a = chain;       mul_b = syn1;  end
            3'd2: begin mul_a = chain;       mul_b = chain; end
            3'd3: begin mul_a = chain;       mul_b = syn1;  end
            3'd4: begin mul_a = chain;       mul_b = chain; end
            3'd5: begin mul_a = syn3 ^ cube; mul_b = chain; end
            default: begin mul_a = chain;    mul_b = syn1;  end
        endcase
    end

    gf_multiplier u_mul (
        .a(mul_a),
        .b(mul_b),
        .p(mul_p)
    );

`ifdef BCH_KES_FAIL_DETECT_EN
    logic unc_q;
    assign uncorrectable = unc_q;
`else
    assign uncorrectable = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step      <= '0;
            syn1      <= '0;
            syn3      <= '0;
            chain     <= '0;
            cube      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            lambda1   <= '0;
            lambda2   <= '0;
            err_cnt   <= '0;
`ifdef BCH_KES_FAIL_DETECT_EN
            unc_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        syn1     <= s1;
                        syn3     <= s3;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    chain <= mul_p;
                    if (step == 3'd1) begin
                        cube <= mul_p;
                    end
                    if (step == 3'd5) begin
                        // With S1=0 the inverse term is 0, so lambda2 collapses to 0 on its own.
                        lambda1   <= syn1;
                        lambda2   <= mul_p;
                        if (syn1 == '0) begin
                            err_cnt <= 2'd0;
                        end else if (mul_p == '0) begin
                            err_cnt <= 2'd1;
                        end else begin
                            err_cnt <= 2'd2;
                        end
`ifdef BCH_KES_FAIL_DETECT_EN
                        unc_q     <= (syn1 == '0) && (syn3 != '0);
`endif
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef BCH_KES_FAIL_DETECT_EN
                        unc_q     <= 1'b0;
`endif
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bch_key_eq_solver.sv
// Scoreboard bench for bch_key_eq_solver: log/antilog GF(16) model, directed and random syndromes.
module tb_bch_key_eq_solver;

    typedef struct {
        logic [3:0] l1;
        logic [3:0] l2;
        logic [1:0] ec;
        logic       unc;
        int         acc_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] s1 = '0;
    logic [3:0] s3 = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] lambda1;
    logic [3:0] lambda2;
    logic [1:0] err_cnt;
    logic       uncorrectable;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   exp_tbl[15];
    int   log_tbl[16];

    bch_key_eq_solver dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .s1(s1),
        .s3(s3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lambda1(lambda1),
        .lambda2(lambda2),
        .err_cnt(err_cnt),
        .uncorrectable(uncorrectable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Powers of alpha generated from x^4 = x + 1.
    task automatic buildTables();
        int v = 1;
        log_tbl[0] = 0;
        for (int i = 0; i < 15; i++) begin
            exp_tbl[i] = v;
            log_tbl[v] = i;
            v = v << 1;
            if (v & 16) v = (v ^ 16) ^ 3;
        end
    endtask

    function automatic int gmul(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return exp_tbl[(log_tbl[x] + log_tbl[y]) % 15];
    endfunction

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   cube;
        int   inv;
        e.l1  = 4'(a);
        e.unc = 1'b0;
        e.acc_cyc = 0;
        if (a == 0) begin
            e.l2 = 4'd0;
            e.ec = 2'd0;
`ifdef BCH_KES_FAIL_DETECT_EN
            e.unc = (b != 0);
`endif
        end else begin
            cube = exp_tbl[(3 * log_tbl[a]) % 15];
            inv  = exp_tbl[(15 - log_tbl[a]) % 15];
            e.l2 = 4'(gmul(b ^ cube, inv));
            e.ec = (e.l2 == 0) ? 2'd1 : 2'd2;
        end
        return e;
    endfunction

    task automatic applyStimulus(input int a, input int b, input bit push, output int acc_cyc);
        exp_t e;
        int   wait_cnt = 0;
        acc_cyc  = -1;
        s1       = 4'(a);
        s3       = 4'(b);
        in_valid = 1'b1;
        while (!in_ready && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        s1       = 4'($urandom_range(0, 15));
        s3       = 4'($urandom_range(0, 15));
        if (push) begin
            e = model(a, b);
            e.acc_cyc = acc_cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic waitIdle(input bit random_ready);
        int n = 0;
        while (!in_ready && n < 200) begin
            if (random_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle_timeout", int'(in_ready), 1);
    endtask

    // Monitor: pops the scoreboard when a result appears and holds it while out_valid stays high.
    initial begin
        exp_t cur;
        bit   prev = 1'b0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev) begin
                        if (sb_q.size() == 0) begin
                            checkOutput("unexpected_output", 1, 0);
                        end else begin
                            cur = sb_q.pop_front();
                            checkOutput("latency", cyc - cur.acc_cyc, 6);
                        end
                    end
                    checkOutput("lambda1", int'(lambda1), int'(cur.l1));
                    checkOutput("lambda2", int'(lambda2), int'(cur.l2));
                    checkOutput("err_cnt", int'(err_cnt), int'(cur.ec));
                    checkOutput("uncorrectable", int'(uncorrectable), int'(cur.unc));
                    checkOutput("in_ready_busy", int'(in_ready), 0);
                end else begin
                    checkOutput("unc_idle", int'(uncorrectable), 0);
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        int acc;
        int last_acc;
        int n;
        buildTables();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_lambda1", int'(lambda1), 0);
        checkOutput("rst_lambda2", int'(lambda2), 0);
        checkOutput("rst_err_cnt", int'(err_cnt), 0);
        checkOutput("rst_unc", int'(uncorrectable), 0);
        rst = 1'b0;

        // Abort a transaction mid-calculation with an asynchronous reset.
        applyStimulus(3, 9, 1'b0, acc);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", int'(in_ready), 1);
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_lambda1", int'(lambda1), 0);
        checkOutput("midrst_lambda2", int'(lambda2), 0);
        checkOutput("midrst_err_cnt", int'(err_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases with out_ready held high: no error, single, double, S1=0/S3!=0.
        out_ready = 1'b1;
        applyStimulus(0, 0, 1'b1, acc);
        waitIdle(1'b0);
        applyStimulus(8, 10, 1'b1, acc);
        waitIdle(1'b0);
        applyStimulus(3, 9, 1'b1, acc);
        waitIdle(1'b0);
        applyStimulus(0, 5, 1'b1, acc);
        waitIdle(1'b0);

        // Back-to-back throughput: accepts exactly eight cycles apart.
        applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), 1'b1, last_acc);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), 1'b1, acc);
            checkOutput("throughput", acc - last_acc, 8);
            last_acc = acc;
        end
        waitIdle(1'b0);

        // Backpressure: result held for five cycles, then a one-cycle out_ready pulse.
        out_ready = 1'b0;
        applyStimulus(3, 9, 1'b1, acc);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("bp_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_out_valid", int'(out_valid), 1);
            checkOutput("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_release_in_ready", int'(in_ready), 1);
        checkOutput("bp_release_out_valid", int'(out_valid), 0);

        // Random syndromes with random backpressure.
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), 1'b1, acc);
            waitIdle(1'b1);
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
